// File: rtl/sram_access_arbiter.sv
// Two-port arbiter for the board SRAM: CPU path (port 0) and loader/DMA (port 1).
// Each access runs IDLE -> SETUP -> ACCESS (WAIT_CYCLES) -> DONE; strobes decode from the registered state.
module sram_access_arbiter #(
   parameter int ADDR_W      = 20,
   parameter int DATA_W      = 16,
   parameter int WAIT_CYCLES = 3,
   parameter int RR          = 1
) (
   input  logic              Clk,
   input  logic              Reset_n,
   input  logic              P0_Req,
   input  logic              P1_Req,
   input  logic              P0_WE,
   input  logic              P1_WE,
   input  logic [ADDR_W-1:0] P0_Addr,
   input  logic [ADDR_W-1:0] P1_Addr,
   input  logic [DATA_W-1:0] P0_WData,
   input  logic [DATA_W-1:0] P1_WData,
   output logic              P0_Ack,
   output logic              P1_Ack,
   output logic [DATA_W-1:0] P0_RData,
   output logic [DATA_W-1:0] P1_RData,
   output logic [1:0]        Grant,
   output logic              Busy,
   output logic [ADDR_W-1:0] SRAM_ADDR,
   output logic [DATA_W-1:0] SRAM_WDATA,
   input  logic [DATA_W-1:0] SRAM_RDATA,
   output logic              SRAM_CE_N,
   output logic              SRAM_OE_N,
   output logic              SRAM_WE_N,
   output logic              Data_Drive
);

   localparam int CNT_W = 4;

   typedef enum logic [1:0] {IDLE, SETUP, ACCESS, DONE} state_t;

   generate
      if (WAIT_CYCLES < 1 || WAIT_CYCLES > 15) begin : gBadWait
         $error("sram_access_arbiter: WAIT_CYCLES must be within 1..15");
      end
   endgenerate

   state_t              state_q, state_d;
   logic [CNT_W-1:0]    cnt_q, cnt_d;
   logic [1:0]          grant_q, grant_d;
   logic                lastGrant_q, lastGrant_d;
   logic                we_q, we_d;
   logic [ADDR_W-1:0]   addr_q, addr_d;
   logic [DATA_W-1:0]   wData_q, wData_d;
   logic [DATA_W-1:0]   rData0_q, rData0_d;
   logic [DATA_W-1:0]   rData1_q, rData1_d;
   logic                pickP1;

   // lastGrant_q = 1 means port 1 was served last, so port 0 wins the first tie.
   always_ff @(posedge Clk or negedge Reset_n) begin
      if (!Reset_n) begin
         state_q     <= IDLE;
         cnt_q       <= '0;
         grant_q     <= '0;
         lastGrant_q <= 1'b1;
         we_q        <= 1'b0;
         addr_q      <= '0;
         wData_q     <= '0;
         rData0_q    <= '0;
         rData1_q    <= '0;
      end else begin
         state_q     <= state_d;
         cnt_q       <= cnt_d;
         grant_q     <= grant_d;
         lastGrant_q <= lastGrant_d;
         we_q        <= we_d;
         addr_q      <= addr_d;
         wData_q     <= wData_d;
         rData0_q    <= rData0_d;
         rData1_q    <= rData1_d;
      end
   end

   always_comb begin
      state_d     = state_q;
      cnt_d       = cnt_q;
      grant_d     = grant_q;
      lastGrant_d = lastGrant_q;
      we_d        = we_q;
      addr_d      = addr_q;
      wData_d     = wData_q;
      rData0_d    = rData0_q;
      rData1_d    = rData1_q;
      pickP1      = 1'b0;
      case (state_q)
         IDLE: begin
            if (P0_Req || P1_Req) begin
               if (P0_Req && P1_Req) begin
                  pickP1 = (RR != 0) ? !lastGrant_q : 1'b0;
               end else begin
                  pickP1 = P1_Req;
               end
               grant_d     = pickP1 ? 2'b10 : 2'b01;
               lastGrant_d = pickP1;
               we_d        = pickP1 ? P1_WE    : P0_WE;
               addr_d      = pickP1 ? P1_Addr  : P0_Addr;
               wData_d     = pickP1 ? P1_WData : P0_WData;
               state_d     = SETUP;
            end
         end
         SETUP: begin
            cnt_d   = CNT_W'(WAIT_CYCLES - 1);
            state_d = ACCESS;
         end
         ACCESS: begin
            // Read data is sampled on the final strobe cycle so it is already valid in DONE.
            if (cnt_q == '0) begin
               state_d = DONE;
               if (!we_q) begin
                  if (grant_q[0]) begin
                     rData0_d = SRAM_RDATA;
                  end else begin
                     rData1_d = SRAM_RDATA;
                  end
               end
            end else begin
               cnt_d = cnt_q - CNT_W'(1);
            end
         end
         DONE: begin
            grant_d = 2'b00;
            state_d = IDLE;
         end
         default: begin
            state_d = IDLE;
         end
      endcase
   end

   assign SRAM_CE_N  = !((state_q == SETUP) || (state_q == ACCESS));
   assign SRAM_OE_N  = !((state_q == ACCESS) && !we_q);
   assign SRAM_WE_N  = !((state_q == ACCESS) && we_q);
   assign Data_Drive = we_q && ((state_q == SETUP) || (state_q == ACCESS));
   assign P0_Ack     = (state_q == DONE) && grant_q[0];
   assign P1_Ack     = (state_q == DONE) && grant_q[1];
   assign Busy       = (state_q != IDLE);
   assign Grant      = grant_q;
   assign SRAM_ADDR  = addr_q;
   assign SRAM_WDATA = wData_q;
   assign P0_RData   = rData0_q;
   assign P1_RData   = rData1_q;

endmodule

// File: tb/tb_sram_access_arbiter.sv
// Directed bench for sram_access_arbiter: a round-robin instance (A) and a fixed-priority instance (B)
// share the same requester inputs, each with its own small SRAM model.
module tb_sram_access_arbiter;

   localparam int AW = 20;
   localparam int DW = 16;
   localparam int W  = 3;

   logic          Clk = 1'b0;
   logic          rstN = 1'b0;
   logic          p0Req = 1'b0, p1Req = 1'b0, p0We = 1'b0, p1We = 1'b0;
   logic [AW-1:0] p0Addr = '0, p1Addr = '0;
   logic [DW-1:0] p0WData = '0, p1WData = '0;

   logic          ack0A, ack1A, busyA, ceA, oeA, weA, ddA;
   logic [DW-1:0] rd0A, rd1A, wdA, rdA;
   logic [1:0]    grantA;
   logic [AW-1:0] addrA;
   logic          ack0B, ack1B, busyB, ceB, oeB, weB, ddB;
   logic [DW-1:0] rd0B, rd1B, wdB, rdB;
   logic [1:0]    grantB;
   logic [AW-1:0] addrB;

   logic [DW-1:0] memA [64];
   logic          wrA  [64] = '{default: 1'b0};
   logic [DW-1:0] memB [64];
   logic          wrB  [64] = '{default: 1'b0};

   int checkCnt = 0;
   int passCnt  = 0;

   typedef struct {
      bit            port;
      bit            we;
      logic [AW-1:0] addr;
      logic [DW-1:0] wdata;
      logic [DW-1:0] expRd;
      string         name;
   } vec_t;

   vec_t vecs [6];

   sram_access_arbiter #(.ADDR_W(AW), .DATA_W(DW), .WAIT_CYCLES(W), .RR(1)) dutA (
      .Clk(Clk), .Reset_n(rstN),
      .P0_Req(p0Req), .P1_Req(p1Req), .P0_WE(p0We), .P1_WE(p1We),
      .P0_Addr(p0Addr), .P1_Addr(p1Addr), .P0_WData(p0WData), .P1_WData(p1WData),
      .P0_Ack(ack0A), .P1_Ack(ack1A), .P0_RData(rd0A), .P1_RData(rd1A),
      .Grant(grantA), .Busy(busyA), .SRAM_ADDR(addrA), .SRAM_WDATA(wdA), .SRAM_RDATA(rdA),
      .SRAM_CE_N(ceA), .SRAM_OE_N(oeA), .SRAM_WE_N(weA), .Data_Drive(ddA)
   );

   sram_access_arbiter #(.ADDR_W(AW), .DATA_W(DW), .WAIT_CYCLES(W), .RR(0)) dutB (
      .Clk(Clk), .Reset_n(rstN),
      .P0_Req(p0Req), .P1_Req(p1Req), .P0_WE(p0We), .P1_WE(p1We),
      .P0_Addr(p0Addr), .P1_Addr(p1Addr), .P0_WData(p0WData), .P1_WData(p1WData),
      .P0_Ack(ack0B), .P1_Ack(ack1B), .P0_RData(rd0B), .P1_RData(rd1B),
      .Grant(grantB), .Busy(busyB), .SRAM_ADDR(addrB), .SRAM_WDATA(wdB), .SRAM_RDATA(rdB),
      .SRAM_CE_N(ceB), .SRAM_OE_N(oeB), .SRAM_WE_N(weB), .Data_Drive(ddB)
   );

   always #5 Clk = ~Clk;

   // Power-up contents of the SRAM model; locations written later override these.
   function automatic logic [DW-1:0] initVal(input logic [5:0] a);
      case (a)
         6'h00:   return 16'h1111;
         6'h01:   return 16'h2222;
         6'h02:   return 16'h3333;
         6'h03:   return 16'h4444;
         6'h12:   return 16'h3A5C;
         default: return 16'hDEAD;
      endcase
   endfunction

   function automatic logic [DW-1:0] peekA(input logic [5:0] a);
      return wrA[a] ? memA[a] : initVal(a);
   endfunction

   always @(posedge Clk) begin
      if (!ceA && !weA) begin
         memA[addrA[5:0]] <= wdA;
         wrA[addrA[5:0]]  <= 1'b1;
      end
      if (!ceB && !weB) begin
         memB[addrB[5:0]] <= wdB;
         wrB[addrB[5:0]]  <= 1'b1;
      end
   end

   always_comb begin
      rdA = '0;
      if (!ceA && !oeA) rdA = wrA[addrA[5:0]] ? memA[addrA[5:0]] : initVal(addrA[5:0]);
   end

   always_comb begin
      rdB = '0;
      if (!ceB && !oeB) rdB = wrB[addrB[5:0]] ? memB[addrB[5:0]] : initVal(addrB[5:0]);
   end

   wire logic [8:0] ctlA = {ceA, oeA, weA, ddA, ack1A, ack0A, grantA, busyA};

   // Expected {CE_N,OE_N,WE_N,Data_Drive,Ack1,Ack0,Grant,Busy} c cycles after the request was sampled in IDLE.
   function automatic logic [8:0] expCtl(input int c, input bit we, input bit port);
      logic       act, strobe, busy;
      logic [1:0] g;
      act    = (c >= 1) && (c <= W + 1);
      strobe = (c >= 2) && (c <= W + 1);
      busy   = (c >= 1) && (c <= W + 2);
      g      = busy ? (port ? 2'b10 : 2'b01) : 2'b00;
      return {!act, !(strobe && !we), !(strobe && we), act && we,
              (c == W + 2) && port, (c == W + 2) && !port, g, busy};
   endfunction

   function automatic vec_t mkVec(input bit port, input bit we, input logic [AW-1:0] addr,
                                  input logic [DW-1:0] wdata, input logic [DW-1:0] expRd, input string name);
      vec_t v;
      v.port = port; v.we = we; v.addr = addr; v.wdata = wdata; v.expRd = expRd; v.name = name;
      return v;
   endfunction

   task automatic tick();
      @(posedge Clk);
      #1;
   endtask

   task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
      checkCnt++;
      if (act === exp) begin
         passCnt++;
      end else begin
         $display("[TB] FAIL %s: got %h, expected %h", name, act, exp);
      end
   endtask

   // One complete transaction on instance A, checked cycle by cycle; the idle port's inputs are scrambled.
   task automatic applyStimulus(input vec_t v);
      if (!v.port) begin
         p0Req = 1'b1; p0We = v.we; p0Addr = v.addr; p0WData = v.wdata;
         p1We = !v.we; p1Addr = ~v.addr; p1WData = ~v.wdata;
      end else begin
         p1Req = 1'b1; p1We = v.we; p1Addr = v.addr; p1WData = v.wdata;
         p0We = !v.we; p0Addr = ~v.addr; p0WData = ~v.wdata;
      end
      checkOutput({v.name, "/idle"}, 64'(ctlA), 64'(expCtl(0, v.we, v.port)));
      for (int c = 1; c <= W + 2; c++) begin
         tick();
         checkOutput($sformatf("%s/ctl%0d", v.name, c), 64'(ctlA), 64'(expCtl(c, v.we, v.port)));
         if (c == 1 || c == W + 2) checkOutput($sformatf("%s/addr%0d", v.name, c), 64'(addrA), 64'(v.addr));
         if (c == 1 && v.we) checkOutput({v.name, "/wdata"}, 64'(wdA), 64'(v.wdata));
      end
      if (!v.we) checkOutput({v.name, "/rdata"}, 64'(v.port ? rd1A : rd0A), 64'(v.expRd));
      p0Req = 1'b0;
      p1Req = 1'b0;
      tick();
      if (v.we) checkOutput({v.name, "/model"}, 64'(peekA(v.addr[5:0])), 64'(v.wdata));
   endtask

   initial begin
      #100000;
      $display("[TB] FAIL watchdog: got timeout, expected $finish");
      $fatal(1, "[TB] watchdog expired");
   end

   initial begin
      logic [DW-1:0] vals [4];
      vals = '{16'h1111, 16'h2222, 16'h3333, 16'h4444};

      vecs[0] = mkVec(1'b0, 1'b0, 20'h00012, 16'h0000, 16'h3A5C, "p0_rd_12");
      vecs[1] = mkVec(1'b1, 1'b1, 20'h0FFFF, 16'hBEEF, 16'h0000, "p1_wr_ffff");
      vecs[2] = mkVec(1'b1, 1'b0, 20'h0FFFF, 16'h0000, 16'hBEEF, "p1_rd_ffff");
      vecs[3] = mkVec(1'b0, 1'b1, 20'h00012, 16'h1234, 16'h0000, "p0_wr_12");
      vecs[4] = mkVec(1'b0, 1'b0, 20'h00012, 16'h0000, 16'h1234, "p0_rd_12b");
      vecs[5] = mkVec(1'b1, 1'b0, 20'h00001, 16'h0000, 16'h2222, "p1_rd_01");

      // Reset values
      #22;
      checkOutput("rst/ctlA", 64'(ctlA), 64'(expCtl(0, 1'b0, 1'b0)));
      checkOutput("rst/rdata", 64'({rd0A, rd1A}), 64'(0));
      checkOutput("rst/bus", 64'({addrA, wdA}), 64'(0));
      checkOutput("rst/ctlB", 64'({ceB, oeB, weB, ddB, ack1B, ack0B, grantB, busyB}), 64'(expCtl(0, 1'b0, 1'b0)));
      rstN = 1'b1;
      tick();

      for (int i = 0; i < 6; i++) applyStimulus(vecs[i]);
      checkOutput("hold/p0", 64'(rd0A), 64'(16'h1234));
      checkOutput("hold/p1", 64'(rd1A), 64'(16'h2222));

      // Tie: A alternates 0,1,0,1; B (fixed priority) serves port 0 only, then port 1 once port 0 drops.
      p0Req = 1'b1; p0We = 1'b0; p0Addr = 20'h00000;
      p1Req = 1'b1; p1We = 1'b0; p1Addr = 20'h00002;
      for (int c = 1; c <= 23; c++) begin
         tick();
         checkOutput($sformatf("rr/ackA%0d", c), 64'({ack1A, ack0A}),
                     64'((c == 5 || c == 17) ? 2'b01 : (c == 11 || c == 23) ? 2'b10 : 2'b00));
         checkOutput($sformatf("fp/ackB%0d", c), 64'({ack1B, ack0B}), 64'((c % 6 == 5) ? 2'b01 : 2'b00));
         if (c % 6 == 1) begin
            checkOutput($sformatf("rr/grantA%0d", c), 64'(grantA), 64'(((c / 6) % 2 == 0) ? 2'b01 : 2'b10));
            checkOutput($sformatf("fp/grantB%0d", c), 64'(grantB), 64'(2'b01));
         end
         if (c == 5)  checkOutput("rr/rd0", 64'(rd0A), 64'(16'h1111));
         if (c == 11) checkOutput("rr/rd1", 64'(rd1A), 64'(16'h3333));
         if (c == 23) p0Req = 1'b0;
      end
      for (int c = 24; c <= 29; c++) begin
         tick();
         checkOutput($sformatf("fp/ackB%0d", c), 64'({ack1B, ack0B}), 64'((c == 29) ? 2'b10 : 2'b00));
         if (c == 25) checkOutput("fp/grantB_p1", 64'(grantB), 64'(2'b10));
         if (c == 29) p1Req = 1'b0;
      end
      tick();

      // Reset asserted during the second ACCESS cycle of a write
      p0Req = 1'b1; p0We = 1'b1; p0Addr = 20'h00020; p0WData = 16'h5555;
      tick(); tick(); tick();
      checkOutput("abort/pre", 64'(ctlA), 64'(expCtl(3, 1'b1, 1'b0)));
      #2;
      rstN = 1'b0;
      #1;
      checkOutput("abort/async", 64'(ctlA), 64'(expCtl(0, 1'b0, 1'b0)));
      checkOutput("abort/addr", 64'(addrA), 64'(0));
      p0Req = 1'b0; p0We = 1'b0;
      #10;
      rstN = 1'b1;
      for (int c = 0; c < 3; c++) begin
         tick();
         checkOutput($sformatf("abort/idle%0d", c), 64'(ctlA), 64'(expCtl(0, 1'b0, 1'b0)));
      end
      applyStimulus(mkVec(1'b0, 1'b0, 20'h00003, 16'h0000, 16'h4444, "abort/fresh"));

      // Back-to-back port 0 reads: Ack every W+3 cycles, RData held between Acks
      p0Req = 1'b1; p0We = 1'b0; p0Addr = 20'h00000;
      for (int c = 1; c <= 23; c++) begin
         tick();
         checkOutput($sformatf("b2b/ack%0d", c), 64'(ack0A), 64'(c % 6 == 5));
         checkOutput($sformatf("b2b/rd%0d", c), 64'(rd0A), 64'((c < 5) ? 16'h4444 : vals[(c - 5) / 6]));
         if (c % 6 == 5) begin
            if (c < 23) p0Addr = AW'((c + 1) / 6);
            else p0Req = 1'b0;
         end
      end
      tick();

      $display("%0d/%0d checks passed", passCnt, checkCnt);
      $finish;
   end

endmodule
